dma_rd_addr_gen: RTL and testbench

// - Upstream address sequencer for the AXI read DMA.
// - Walks a 2-D DDR region: num_rows rows of bursts_per_row bursts each, rows spaced by row_stride bytes.
// - Drives the DMA's valid/addr request and counts its per-beat ready strobes to track burst completion.
// - Flags any burst that crosses a 4 KB AXI boundary; marks the last beat of each burst for the downstream consumer.

---
 rtl/dma_rd_addr_gen_pkg.sv | 20 ++
 rtl/dma_rd_addr_gen.sv | 164 ++++++++++++++++
 tb/tb_dma_rd_addr_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_rd_addr_gen_pkg.sv
// Shared widths, FSM state type and 4 KB boundary helper for the read DMA address sequencer.
package dma_rd_addr_gen_pkg;

    localparam int unsigned DDR_ADDR_W      = 32;
    localparam int unsigned MIG_BUS_W       = 256;
    localparam int unsigned BURST_BEATS_DEF = 7;
    localparam int unsigned BOUNDARY_BYTES  = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // True when a burst starting at this page offset runs past the 4 KB page end.
    function automatic logic crosses_4k(input logic [11:0] addr_lo, input int unsigned burst_bytes);
        return (32'(addr_lo) + burst_bytes) > 32'(BOUNDARY_BYTES);
    endfunction

endpackage

// File: rtl/dma_rd_addr_gen.sv
// Walks a 2-D DDR region burst by burst, presenting addresses to the read DMA
// and tracking burst completion from its per-beat ready strobes.
module dma_rd_addr_gen
    import dma_rd_addr_gen_pkg::*;
#(
    parameter int unsigned BURST_BEATS = BURST_BEATS_DEF,
    parameter int unsigned BEAT_BYTES  = MIG_BUS_W / 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DDR_ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]      bursts_per_row,
    input  logic [CNT_W-1:0]      num_rows,
    input  logic [DDR_ADDR_W-1:0] row_stride,
    output logic                  busy,
    output logic                  done,
    output logic                  boundary_err,
    output logic                  dma_valid,
    output logic [DDR_ADDR_W-1:0] dma_addr,
    input  logic                  dma_ready,
    output logic                  beat_last
);

    localparam int unsigned BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int unsigned BURST_BYTES = BURST_BEATS * BEAT_BYTES;

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [CNT_W-1:0]        burst_q, burst_d;
    logic [CNT_W-1:0]        row_q, row_d;
    logic [CNT_W-1:0]        bpr_q, bpr_d;
    logic [CNT_W-1:0]        rows_q, rows_d;
    logic [DDR_ADDR_W-1:0]   stride_q, stride_d;
    logic [DDR_ADDR_W-1:0]   row_base_q, row_base_d;
    logic [DDR_ADDR_W-1:0]   addr_q, addr_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    berr_q, berr_d;

    logic                    last_beat;
    logic [DDR_ADDR_W-1:0]   next_row_base;
    logic [DDR_ADDR_W-1:0]   next_burst_addr;

    assign last_beat       = (state_q == ST_RUN) && dma_ready && (beat_q == BEAT_W'(BURST_BEATS - 1));
    assign next_row_base   = row_base_q + stride_q;
    assign next_burst_addr = addr_q + DDR_ADDR_W'(BURST_BYTES);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            burst_q    <= '0;
            row_q      <= '0;
            bpr_q      <= '0;
            rows_q     <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            burst_q    <= burst_d;
            row_q      <= row_d;
            bpr_q      <= bpr_d;
            rows_q     <= rows_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            berr_q     <= berr_d;
        end
    end

    // Next-state, counters and address sequencing
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        burst_d    = burst_q;
        row_d      = row_q;
        bpr_d      = bpr_q;
        rows_d     = rows_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        berr_d     = berr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bpr_d      = bursts_per_row;
                    rows_d     = num_rows;
                    stride_d   = row_stride;
                    row_base_d = base_addr;
                    beat_d     = '0;
                    burst_d    = '0;
                    row_d      = '0;
                    berr_d     = 1'b0;
                    busy_d     = 1'b1;
                    if ((bursts_per_row == '0) || (num_rows == '0)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RUN;
                        valid_d = 1'b1;
                        addr_d  = base_addr;
                        berr_d  = crosses_4k(base_addr[11:0], BURST_BYTES);
                    end
                end
            end
            ST_RUN: begin
                if (dma_ready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        beat_d = '0;
                        if (burst_q != (bpr_q - CNT_W'(1))) begin
                            burst_d = burst_q + CNT_W'(1);
                            addr_d  = next_burst_addr;
                            berr_d  = berr_q | crosses_4k(next_burst_addr[11:0], BURST_BYTES);
                        end else if (row_q != (rows_q - CNT_W'(1))) begin
                            burst_d    = '0;
                            row_d      = row_q + CNT_W'(1);
                            row_base_d = next_row_base;
                            addr_d     = next_row_base;
                            berr_d     = berr_q | crosses_4k(next_row_base[11:0], BURST_BYTES);
                        end else begin
                            valid_d = 1'b0;
                            state_d = ST_FIN;
                        end
                    end
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign boundary_err = berr_q;
    assign dma_valid    = valid_q;
    assign dma_addr     = addr_q;
    assign beat_last    = last_beat;

endmodule

// File: tb/tb_dma_rd_addr_gen.sv
// Directed bench for dma_rd_addr_gen: a reference address list is queued at each start
// and popped as the DUT presents each burst.
module tb_dma_rd_addr_gen;
    import dma_rd_addr_gen_pkg::*;

    localparam int unsigned AW          = DDR_ADDR_W;
    localparam int unsigned CW          = 16;
    localparam int          BEATS       = 7;
    localparam int unsigned BURST_BYTES = 224;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] bursts_per_row;
    logic [CW-1:0] num_rows;
    logic [AW-1:0] row_stride;
    logic          busy;
    logic          done;
    logic          boundary_err;
    logic          dma_valid;
    logic [AW-1:0] dma_addr;
    logic          dma_ready;
    logic          beat_last;

    int            n_checks;
    int            n_fail;
    logic [AW-1:0] exp_q[$];
    logic          exp_berr;

    dma_rd_addr_gen #(
        .BURST_BEATS (BEATS),
        .BEAT_BYTES  (32),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .bursts_per_row (bursts_per_row),
        .num_rows       (num_rows),
        .row_stride     (row_stride),
        .busy           (busy),
        .done           (done),
        .boundary_err   (boundary_err),
        .dma_valid      (dma_valid),
        .dma_addr       (dma_addr),
        .dma_ready      (dma_ready),
        .beat_last      (beat_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Builds the reference address list, then pulses start for one cycle.
    task automatic start_cfg(input logic [AW-1:0] base, input logic [CW-1:0] bpr,
                             input logic [CW-1:0] rows, input logic [AW-1:0] stride);
        logic [AW-1:0] a;
        exp_q.delete();
        exp_berr = 1'b0;
        for (int r = 0; r < int'(rows); r++) begin
            for (int b = 0; b < int'(bpr); b++) begin
                a = base + AW'(r) * stride + AW'(b * int'(BURST_BYTES));
                exp_q.push_back(a);
                if (32'(a[11:0]) + BURST_BYTES > 32'd4096) exp_berr = 1'b1;
            end
        end
        base_addr      = base;
        bursts_per_row = bpr;
        num_rows       = rows;
        row_stride     = stride;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    // Strobes ready per beat (with random stalls) until the DUT drops valid.
    task automatic run_bursts(input bit spur);
        int            guard;
        int            beat;
        int            total;
        bit            popped;
        logic [AW-1:0] cur;
        guard  = 0;
        beat   = 0;
        total  = 0;
        popped = 1'b0;
        cur    = '0;
        while (dma_valid === 1'b1 && guard < 4000) begin
            guard++;
            if (beat == 0 && !popped) begin
                check("burst_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() == 0) break;
                cur    = exp_q.pop_front();
                popped = 1'b1;
                check("burst_addr", 64'(dma_addr), 64'(cur));
            end
            if ($urandom_range(0, 3) == 0) begin
                dma_ready = 1'b0;
                tick();
                check("addr_hold_stall", 64'(dma_addr), 64'(cur));
                continue;
            end
            if (spur && total == 10) begin
                start          = 1'b1;
                base_addr      = 32'hDEAD_0000;
                bursts_per_row = 16'd9;
                num_rows       = 16'd9;
            end
            dma_ready = 1'b1;
            #1;
            check("beat_last", 64'(beat_last), 64'(beat == BEATS - 1));
            check("busy_run", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
            dma_ready = 1'b0;
            start     = 1'b0;
            total++;
            beat = (beat + 1) % BEATS;
            if (beat == 0) popped = 1'b0;
            else check("addr_hold_beat", 64'(dma_addr), 64'(cur));
        end
        check("run_no_timeout", 64'(guard < 4000), 64'd1);
        check("all_bursts_issued", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic finish_seq();
        check("fin_valid_low", 64'(dma_valid), 64'd0);
        check("fin_done_low", 64'(done), 64'd0);
        tick();
        check("done_pulse", 64'(done), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        check("berr_at_done", 64'(boundary_err), 64'(exp_berr));
        tick();
        check("done_one_cycle", 64'(done), 64'd0);
        check("berr_sticky", 64'(boundary_err), 64'(exp_berr));
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        start          = 1'b0;
        base_addr      = '0;
        bursts_per_row = '0;
        num_rows       = '0;
        row_stride     = '0;
        dma_ready      = 1'b0;
        exp_berr       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_berr", 64'(boundary_err), 64'd0);
        check("rst_valid", 64'(dma_valid), 64'd0);
        check("rst_addr", 64'(dma_addr), 64'd0);

        // Single burst
        start_cfg(32'h1000, 16'd1, 16'd1, 32'h0);
        check("single_valid", 64'(dma_valid), 64'd1);
        check("single_busy", 64'(busy), 64'd1);
        run_bursts(1'b0);
        finish_seq();

        // 2-D walk with a spurious start mid-run
        start_cfg(32'h0, 16'd3, 16'd2, 32'h400);
        check("walk_valid", 64'(dma_valid), 64'd1);
        run_bursts(1'b1);
        finish_seq();

        // Zero size
        start_cfg(32'h3000, 16'd5, 16'd0, 32'h100);
        check("zero_valid_1", 64'(dma_valid), 64'd0);
        check("zero_busy_1", 64'(busy), 64'd1);
        finish_seq();
        check("zero_valid_end", 64'(dma_valid), 64'd0);

        // Boundary crossing then clear by next start
        start_cfg(32'hFC0, 16'd1, 16'd1, 32'h0);
        check("bnd_set_at_entry", 64'(boundary_err), 64'd1);
        run_bursts(1'b0);
        finish_seq();
        start_cfg(32'h0, 16'd1, 16'd1, 32'h0);
        check("bnd_cleared", 64'(boundary_err), 64'd0);
        run_bursts(1'b0);
        finish_seq();

        // Reset mid-burst, then fresh start
        start_cfg(32'h2000, 16'd2, 16'd1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            dma_ready = 1'b1;
            tick();
        end
        dma_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_valid", 64'(dma_valid), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_addr", 64'(dma_addr), 64'd0);
        start_cfg(32'h2000, 16'd1, 16'd1, 32'h0);
        check("restart_addr", 64'(dma_addr), 64'h2000);
        run_bursts(1'b0);
        finish_seq();

        // dma_ready in IDLE must be ignored
        for (int i = 0; i < 3; i++) begin
            dma_ready = 1'b1;
            #1;
            check("idle_beat_last", 64'(beat_last), 64'd0);
            tick();
        end
        dma_ready = 1'b0;
        check("idle_valid", 64'(dma_valid), 64'd0);
        start_cfg(32'h5000, 16'd1, 16'd1, 32'h0);
        run_bursts(1'b0);
        finish_seq();

        // Address wrap at top of space, with boundary crossing on the wrapped burst
        start_cfg(32'hFFFF_FF80, 16'd2, 16'd1, 32'h0);
        run_bursts(1'b0);
        finish_seq();

        // A few random shapes
        for (int k = 0; k < 4; k++) begin
            logic [AW-1:0] rb;
            logic [AW-1:0] rs;
            rb = AW'($urandom) & 32'hFFFF_FFE0;
            rs = AW'($urandom_range(0, 32'h3000)) & 32'hFFFF_FFE0;
            start_cfg(rb, CW'($urandom_range(1, 3)), CW'($urandom_range(1, 3)), rs);
            run_bursts(1'b0);
            finish_seq();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
